// File: rtl/imem_boot_pkg.sv
// Shared definitions for the instruction-memory boot sequencer.
// Holds the sequencer state encoding, default sizing parameters and the
// load-length legality check used when a start request is evaluated.
package imem_boot_pkg;

  localparam int MEM_BYTES_DEFAULT     = 256;
  localparam int SETTLE_CYCLES_DEFAULT = 2;

  // Byte counter / length width: must represent MEM_BYTES itself (256).
  localparam int CNT_W    = 9;
  // Width of the settle down-counter.
  localparam int SETTLE_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_RUN    = 3'd3,
    ST_HALT   = 3'd4
  } state_e;

  // A load length is legal when it is non-zero and fits in the memory.
  function automatic logic len_ok(input logic [CNT_W-1:0] len, input int max_len);
    return (len != '0) && (int'(len) <= max_len);
  endfunction

endpackage

// File: rtl/settle_timer.sv
// Settle wait counter for the boot sequencer.
// Ports:
//   clk     - clock
//   rst     - synchronous active-high reset
//   load    - load 'count' into the down-counter
//   count   - number of cycles to wait after the load cycle's successor
//   expired - high while the counter is zero
module settle_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] count,
  output logic             expired
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = count;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/imem_boot_sequencer.sv
// Instruction-memory boot sequencer.
// Copies byte_count bytes from a valid/ready byte stream into instruction
// memory, waits SETTLE_CYCLES idle cycles, runs the processor until its PC
// reaches halt_addr, then reports completion.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   start, byte_count   - begin a load of byte_count bytes (IDLE only)
//   in_valid/in_data    - source byte stream, in_ready accepts a byte
//   halt_addr/pc_output - run ends when the processor PC equals halt_addr
//   We/write_address/write_data - instruction memory write port
//   pc_enable           - processor run enable (RUN only)
//   busy                - sequencer not IDLE
//   done                - one-cycle run-complete pulse
//   error               - one-cycle pulse for an illegal start length
module imem_boot_sequencer
  import imem_boot_pkg::*;
#(
  parameter int MEM_BYTES     = MEM_BYTES_DEFAULT,
  parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] byte_count,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  input  logic [31:0]      halt_addr,
  input  logic [31:0]      pc_output,
  output logic             We,
  output logic [31:0]      write_address,
  output logic [7:0]       write_data,
  output logic             pc_enable,
  output logic             busy,
  output logic             done,
  output logic             error
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic             we_q, we_d;
  logic [31:0]      waddr_q, waddr_d;
  logic [7:0]       wdata_q, wdata_d;
  logic             error_q, error_d;

  logic xfer, last_xfer, start_req, start_ok, start_bad, settle_expired;

  assign xfer      = in_valid && in_ready;
  assign last_xfer = xfer && (cnt_q == (len_q - CNT_W'(1)));
  assign start_req = (state_q == ST_IDLE) && start;
  assign start_ok  = start_req && len_ok(byte_count, MEM_BYTES);
  assign start_bad = start_req && !len_ok(byte_count, MEM_BYTES);

  // Loaded on the final transfer, so the wait is counted from the cycle
  // that carries the final write.
  settle_timer #(
    .WIDTH (SETTLE_W)
  ) u_settle (
    .clk     (clk),
    .rst     (rst),
    .load    (last_xfer),
    .count   (SETTLE_W'(SETTLE_CYCLES)),
    .expired (settle_expired)
  );

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start_ok)                state_d = ST_LOAD;
      ST_LOAD:   if (last_xfer)               state_d = ST_SETTLE;
      ST_SETTLE: if (settle_expired)          state_d = ST_RUN;
      ST_RUN:    if (pc_output == halt_addr)  state_d = ST_HALT;
      ST_HALT:                                state_d = ST_IDLE;
      default:                                state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    in_ready  = (state_q == ST_LOAD);
    pc_enable = (state_q == ST_RUN);
    busy      = (state_q != ST_IDLE);
    done      = (state_q == ST_HALT);
  end

  // Byte counter, latched length and the registered memory write port.
  always_comb begin
    cnt_d   = cnt_q;
    len_d   = len_q;
    we_d    = xfer;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    error_d = start_bad;
    if (start_ok) begin
      cnt_d = '0;
      len_d = byte_count;
    end
    if (xfer) begin
      waddr_d = {{(32-CNT_W){1'b0}}, cnt_q};
      wdata_d = in_data;
      cnt_d   = cnt_q + CNT_W'(1);
    end
  end

  // A transfer coinciding with reset is dropped: its write never issues.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      len_q   <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      error_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      error_q <= error_d;
    end
  end

  assign We            = we_q;
  assign write_address = waddr_q;
  assign write_data    = wdata_q;
  assign error         = error_q;

endmodule

// File: tb/tb_imem_boot_sequencer.sv
module tb_imem_boot_sequencer;

  localparam int EV_WRITE = 0;
  localparam int EV_ERROR = 1;
  localparam int EV_DONE  = 2;

  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic [7:0]  data;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [8:0]  byte_count;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic [31:0] halt_addr;
  logic [31:0] pc_output;
  logic        We;
  logic [31:0] write_address;
  logic [7:0]  write_data;
  logic        pc_enable;
  logic        busy;
  logic        done;
  logic        error;

  int  checks = 0;
  int  errors = 0;
  ev_t exp_q[$];

  imem_boot_sequencer dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .byte_count    (byte_count),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_ready      (in_ready),
    .halt_addr     (halt_addr),
    .pc_output     (pc_output),
    .We            (We),
    .write_address (write_address),
    .write_data    (write_data),
    .pc_enable     (pc_enable),
    .busy          (busy),
    .done          (done),
    .error         (error)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_w(input int a, input logic [7:0] d);
    ev_t e;
    e.kind = EV_WRITE; e.addr = 32'(a); e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic push_ev(input int kind);
    ev_t e;
    e.kind = kind; e.addr = '0; e.data = '0;
    exp_q.push_back(e);
  endtask

  // Scoreboard monitor: each observed event must match the oldest expectation.
  task automatic sb_check(input int kind, input logic [31:0] a, input logic [7:0] d);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event kind=%0d addr=%0h data=%0h expected none", kind, a, d);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.addr !== a || e.data !== d) begin
        errors++;
        $display("FAIL event kind=%0d addr=%0h data=%0h expected kind=%0d addr=%0h data=%0h",
                 kind, a, d, e.kind, e.addr, e.data);
      end
    end
  endtask

  always @(negedge clk) begin
    if (We === 1'b1)    sb_check(EV_WRITE, write_address, write_data);
    if (error === 1'b1) sb_check(EV_ERROR, 32'h0, 8'h0);
    if (done === 1'b1)  sb_check(EV_DONE, 32'h0, 8'h0);
  end

  task automatic wait_idle(input int budget);
    int n = 0;
    @(negedge clk);
    while (busy !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("idle_within_budget", {31'b0, busy}, 32'h0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},  {31'b0, busy},      32'h0);
    chk({tag, "_ready"}, {31'b0, in_ready},  32'h0);
    chk({tag, "_we"},    {31'b0, We},        32'h0);
    chk({tag, "_pcen"},  {31'b0, pc_enable}, 32'h0);
    chk({tag, "_done"},  {31'b0, done},      32'h0);
    chk({tag, "_err"},   {31'b0, error},     32'h0);
    chk({tag, "_addr"},  write_address,      32'h0);
    chk({tag, "_data"},  {24'b0, write_data}, 32'h0);
  endtask

  initial begin
    int k;
    logic [4:0] pat;
    rst = 1'b1; start = 1'b0; byte_count = '0; in_valid = 1'b0; in_data = '0;
    halt_addr = 32'hFFFF_FFFF; pc_output = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk_all_zero("reset");

    // 12 back-to-back bytes, then RUN with PC stepping 0,4,8
    halt_addr = 32'd8; pc_output = 32'd0;
    start = 1'b1; byte_count = 9'd12;
    tick();
    start = 1'b0; byte_count = 9'd3;   // must not affect the running load
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1; in_data = 8'(i);
      push_w(i, 8'(i));
      tick();
    end
    in_data = 8'hFF;                   // still offered: must not be accepted
    @(negedge clk);
    chk("ready_after_last", {31'b0, in_ready}, 32'h0);
    chk("pcen_last_we",     {31'b0, pc_enable}, 32'h0);
    tick(); in_valid = 1'b0;
    @(negedge clk); chk("pcen_settle1", {31'b0, pc_enable}, 32'h0);
    tick();
    @(negedge clk); chk("pcen_settle2", {31'b0, pc_enable}, 32'h0);
    tick();
    @(negedge clk); chk("pcen_run", {31'b0, pc_enable}, 32'h1);
    tick(); pc_output = 32'd4; start = 1'b1; byte_count = 9'd5;  // ignored in RUN
    @(negedge clk);
    chk("pcen_run_pc4", {31'b0, pc_enable}, 32'h1);
    tick(); start = 1'b0; pc_output = 32'd8; push_ev(EV_DONE);
    @(negedge clk); chk("pcen_run_pc8", {31'b0, pc_enable}, 32'h1);
    tick();
    @(negedge clk);
    chk("pcen_halt", {31'b0, pc_enable}, 32'h0);
    chk("busy_halt", {31'b0, busy}, 32'h1);
    tick();
    @(negedge clk); chk("busy_after_halt", {31'b0, busy}, 32'h0);

    // byte_count=3 with in_valid 1,0,1,0,1 and a start pulse during LOAD
    halt_addr = 32'h100; pc_output = 32'h100;
    start = 1'b1; byte_count = 9'd3;
    tick();
    start = 1'b0;
    pat = 5'b10101; k = 0;
    for (int j = 0; j < 5; j++) begin
      in_valid = pat[j]; in_data = 8'hA0 + 8'(j);
      if (pat[j]) begin push_w(k, 8'hA0 + 8'(j)); k++; end
      start = (j == 1); byte_count = (j == 1) ? 9'd1 : 9'd3;
      tick();
    end
    in_valid = 1'b0; start = 1'b0;
    push_ev(EV_DONE);
    wait_idle(20);

    // illegal lengths 0 and 257
    start = 1'b1; byte_count = 9'd0; push_ev(EV_ERROR);
    tick(); start = 1'b0;
    @(negedge clk); chk("busy_err0", {31'b0, busy}, 32'h0);
    tick();
    start = 1'b1; byte_count = 9'd257; push_ev(EV_ERROR);
    tick(); start = 1'b0;
    @(negedge clk); chk("busy_err257", {31'b0, busy}, 32'h0);
    tick(); tick();
    @(negedge clk); chk("busy_err_after", {31'b0, busy}, 32'h0);

    // full-memory load: addresses 0..255, no wrap
    start = 1'b1; byte_count = 9'd256;
    tick(); start = 1'b0;
    for (int i = 0; i < 256; i++) begin
      in_valid = 1'b1; in_data = 8'(i) ^ 8'h5A;
      push_w(i, 8'(i) ^ 8'h5A);
      tick();
    end
    in_valid = 1'b0;
    push_ev(EV_DONE);
    wait_idle(20);

    // reset after 5 of 10 bytes, transfer on the reset edge is dropped
    start = 1'b1; byte_count = 9'd10;
    tick(); start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = 8'h30 + 8'(i);
      push_w(i, 8'h30 + 8'(i));
      tick();
    end
    in_data = 8'hEE; rst = 1'b1; start = 1'b1; byte_count = 9'd4;
    tick();
    rst = 1'b0; in_valid = 1'b0; start = 1'b0;
    @(negedge clk);
    chk_all_zero("midrst");
    start = 1'b1; byte_count = 9'd2;
    tick(); start = 1'b0;
    in_valid = 1'b1; in_data = 8'h55; push_w(0, 8'h55);
    tick();
    in_data = 8'h66; push_w(1, 8'h66);
    tick();
    in_valid = 1'b0;
    push_ev(EV_DONE);
    wait_idle(20);

    repeat (3) tick();
    @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout reached expected completion");
    $fatal(1, "timeout");
  end

endmodule
